// File: rtl/clock_pkg.sv
// Shared definitions for the clock utilities (period meter, divider, ...).
package clock_pkg;

  // Default counter width for period / high-time measurement.
  localparam int CNT_W_DEF = 32;

  // Period-meter FSM states.
  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_e;

endpackage

// File: rtl/sync_2ff.sv
// 1-bit double-flop synchronizer for asynchronous inputs, reset to 0.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic s1_d, s1_q;
  logic s2_d, s2_q;

  // Next state: shift the input through two stages.
  always_comb begin
    s1_d = d_i;
    s2_d = s1_q;
  end

  // Synchronizer stages with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_o = s2_q;

endmodule

// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous signal in clk_i cycles
// and flags when the signal stops toggling.
module period_meter
  import clock_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int TIMEOUT = 1000000
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sig_i,
  output logic [CNT_W-1:0] period_o,
  output logic [CNT_W-1:0] high_o,
  output logic             valid_o,
  output logic             timeout_o
);

  // Counter value seen in the last cycle before the stall is declared.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic s2;
  logic rise;

  state_e           state_d, state_q;
  logic             s3_d, s3_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic [CNT_W-1:0] hcnt_d, hcnt_q;
  logic [CNT_W-1:0] period_d, period_q;
  logic [CNT_W-1:0] high_d, high_q;
  logic             valid_d, valid_q;
  logic             timeout_d, timeout_q;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (sig_i),
    .q_o   (s2)
  );

  assign rise = s2 & ~s3_q;

  // Edge detect, counters, FSM next state and output updates.
  always_comb begin
    s3_d      = s2;
    state_d   = state_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;
    // Counters saturate rather than wrap; the timeout normally fires long before.
    cnt_d     = (cnt_q != CNT_MAX) ? cnt_q + CNT_ONE : cnt_q;
    hcnt_d    = (s2 && hcnt_q != CNT_MAX) ? hcnt_q + CNT_ONE : hcnt_q;
    if (rise) begin
      cnt_d  = CNT_ONE;
      hcnt_d = CNT_ONE;
    end
    unique case (state_q)
      ST_IDLE: begin
        // First edge only arms: there is no complete period yet.
        if (rise) begin
          state_d   = ST_MEASURE;
          timeout_d = 1'b0;
        end
      end
      ST_MEASURE: begin
        // A rise in the same cycle as the timeout condition wins.
        if (rise) begin
          period_d = cnt_q;
          high_d   = hcnt_q;
          valid_d  = 1'b1;
        end else if (cnt_q == TO_LAST) begin
          state_d   = ST_IDLE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      s3_q      <= 1'b0;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s3_q      <= s3_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign period_o  = period_q;
  assign high_o    = high_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter (TIMEOUT = 500). Time unit: 100 per clk_i cycle.
module tb_period_meter;

  localparam int CW = 32;
  localparam int TO = 500;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1;
  logic          sig_i = 1'b0;
  logic [CW-1:0] period_o;
  logic [CW-1:0] high_o;
  logic          valid_o;
  logic          timeout_o;

  int checks = 0;
  int errors = 0;

  period_meter #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .sig_i     (sig_i),
    .period_o  (period_o),
    .high_o    (high_o),
    .valid_o   (valid_o),
    .timeout_o (timeout_o)
  );

  always #50 clk_i = ~clk_i;

  // Cycle counter and output monitor, sampled on the falling edge.
  int            cyc = 0;
  logic [CW-1:0] per_q[$];
  logic [CW-1:0] hi_q[$];
  int            last_vcyc = 0;
  int            to_rises  = 0;
  int            dbl_valid = 0;
  logic          prev_v    = 1'b0;
  logic          prev_to   = 1'b0;

  always @(posedge clk_i) cyc++;

  always @(negedge clk_i) begin
    if (valid_o) begin
      per_q.push_back(period_o);
      hi_q.push_back(high_o);
      last_vcyc = cyc;
      if (prev_v) dbl_valid++;
    end
    if (timeout_o && !prev_to) to_rises++;
    prev_v  = valid_o;
    prev_to = timeout_o;
  end

  task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance n rising edges, then step just past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic wave(input int h, input int l, input int n);
    for (int i = 0; i < n; i++) begin
      sig_i = 1'b1;
      tick(h);
      sig_i = 1'b0;
      tick(l);
    end
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    sig_i = 1'b0;
    tick(3);
    rst_i = 1'b0;
    tick(3);
  endtask

  typedef struct {
    int h;
    int l;
    int n;
    int nv;
    int per;
    int hi;
    int tos;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int base, tbase, d, bad;

    // Each row: high, low, periods, expected valids, period, high, timeout events.
    tbl[0] = '{h: 50,  l: 50,  n: 5, nv: 4, per: 100, hi: 50,  tos: 0};
    tbl[1] = '{h: 30,  l: 70,  n: 5, nv: 4, per: 100, hi: 30,  tos: 0};
    tbl[2] = '{h: 13,  l: 7,   n: 6, nv: 5, per: 20,  hi: 13,  tos: 0};
    tbl[3] = '{h: 1,   l: 1,   n: 8, nv: 7, per: 2,   hi: 1,   tos: 0};
    tbl[4] = '{h: 3,   l: 1,   n: 6, nv: 5, per: 4,   hi: 3,   tos: 0};
    tbl[5] = '{h: 1,   l: 3,   n: 6, nv: 5, per: 4,   hi: 1,   tos: 0};
    tbl[6] = '{h: 100, l: 399, n: 3, nv: 2, per: 499, hi: 100, tos: 0};
    tbl[7] = '{h: 100, l: 400, n: 3, nv: 0, per: 0,   hi: 0,   tos: 2};

    do_reset();
    check("reset_period", period_o, 0);
    check("reset_high", high_o, 0);
    check("reset_valid", {31'd0, valid_o}, 0);
    check("reset_timeout", {31'd0, timeout_o}, 0);

    // Table-driven steady-state patterns.
    foreach (tbl[k]) begin
      do_reset();
      base  = per_q.size();
      tbase = to_rises;
      wave(tbl[k].h, tbl[k].l, tbl[k].n);
      check($sformatf("v%0d_timeouts", k), to_rises - tbase, tbl[k].tos);
      tick(3);
      check($sformatf("v%0d_nvalid", k), per_q.size() - base, tbl[k].nv);
      for (int i = base; i < per_q.size(); i++) begin
        check($sformatf("v%0d_period[%0d]", k, i - base), per_q[i], tbl[k].per);
        check($sformatf("v%0d_high[%0d]", k, i - base), hi_q[i], tbl[k].hi);
      end
      check($sformatf("v%0d_period_o", k), period_o, tbl[k].per);
    end

    // Duty switch 30/70 -> 13/7 without reset.
    do_reset();
    base = per_q.size();
    wave(30, 70, 4);
    wave(13, 7, 6);
    tick(3);
    check("switch_nvalid", per_q.size() - base, 9);
    for (int i = base; i < per_q.size(); i++) begin
      check("switch_period", per_q[i], (i - base < 4) ? 100 : 20);
      check("switch_high", hi_q[i], (i - base < 4) ? 30 : 13);
    end

    // Stall: timeout TO cycles after the last rise, results held.
    do_reset();
    wave(50, 50, 4);
    base = per_q.size();
    d = 0;
    while (!timeout_o && d < 1000) begin
      @(negedge clk_i);
      d++;
    end
    check("stall_seen", {31'd0, timeout_o}, 1);
    check("stall_delay", cyc - last_vcyc, TO - 1);
    check("stall_period", period_o, 100);
    check("stall_high", high_o, 50);
    check("stall_novalid", per_q.size() - base, 0);
    // Restart: first rise clears timeout without valid, second measures.
    tick(1);
    wave(50, 50, 1);
    check("restart_to_clr", {31'd0, timeout_o}, 0);
    check("restart_novalid", per_q.size() - base, 0);
    wave(50, 50, 1);
    check("restart_valid", per_q.size() - base, 1);
    check("restart_period", period_o, 100);
    check("restart_high", high_o, 50);

    // One-cycle reset in the middle of a high phase.
    do_reset();
    wave(50, 50, 3);
    sig_i = 1'b1;
    tick(20);
    rst_i = 1'b1;
    sig_i = 1'b0;
    tick(1);
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_period", period_o, 0);
    check("midrst_high", high_o, 0);
    check("midrst_valid", {31'd0, valid_o}, 0);
    check("midrst_timeout", {31'd0, timeout_o}, 0);
    tick(10);
    base = per_q.size();
    wave(50, 50, 3);
    tick(3);
    check("midrst_nvalid", per_q.size() - base, 2);
    for (int i = base; i < per_q.size(); i++) begin
      check("midrst_p", per_q[i], 100);
      check("midrst_h", hi_q[i], 50);
    end

    // Asynchronous input: 37.3 ns period against a 10 ns clock.
    do_reset();
    base = per_q.size();
    #3;
    for (int i = 0; i < 1000; i++) begin
      sig_i = 1'b1;
      #186;
      sig_i = 1'b0;
      #187;
    end
    tick(5);
    check("async_nvalid", per_q.size() - base, 999);
    bad = 0;
    for (int i = base; i < per_q.size(); i++)
      if (!(per_q[i] inside {3, 4}) || !(hi_q[i] inside {1, 2, 3})) bad++;
    check("async_range", bad, 0);

    check("valid_one_cycle", dbl_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
